// File: rtl/hazard_unit.sv
// -----------------------------------------------------------------------------
// hazard_unit
//
// Hazard detection and forwarding control for a five-stage pipeline with a
// multi-cycle HI/LO (multiply/divide) unit.
//
// Decisions made here:
//   - stall        : freeze F/D and insert a bubble into E. Raised when a D-stage
//                    operand is produced too late by E or M, or when a HI/LO
//                    instruction reaches D while the unit is busy or starting.
//   - D_fwd_rs/rt  : D-stage operand source (00 RF, 01 E, 10 M, 11 W).
//   - E_fwd_rs/rt  : E-stage operand source (00 pipeline, 10 M, 01 W).
//   - md_busy      : the HI/LO unit is computing.
//   - stall_cnt    : saturating count of stalled cycles.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   D_a1, D_a2                 D-stage rs/rt addresses
//   D_tuse_rs, D_tuse_rt       cycles until operand needed (3 = unused)
//   D_md                       D-stage instruction uses HI/LO
//   E_a1, E_a2, E_a3           E-stage rs/rt/destination addresses
//   E_we, E_tnew               E-stage write enable, cycles until result ready
//   E_start, E_div             E-stage starts multiply (E_div=0) or divide
//   M_a3, M_we, M_tnew         M-stage producer
//   W_a3, W_we                 W-stage producer
//   stall, D_fwd_rs, D_fwd_rt, E_fwd_rs, E_fwd_rt, md_busy, stall_cnt  outputs
// -----------------------------------------------------------------------------
module hazard_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       D_a1,
  input  logic [4:0]       D_a2,
  input  logic [1:0]       D_tuse_rs,
  input  logic [1:0]       D_tuse_rt,
  input  logic             D_md,
  input  logic [4:0]       E_a1,
  input  logic [4:0]       E_a2,
  input  logic [4:0]       E_a3,
  input  logic             E_we,
  input  logic [1:0]       E_tnew,
  input  logic             E_start,
  input  logic             E_div,
  input  logic [4:0]       M_a3,
  input  logic             M_we,
  input  logic [1:0]       M_tnew,
  input  logic [4:0]       W_a3,
  input  logic             W_we,
  output logic             stall,
  output logic [1:0]       D_fwd_rs,
  output logic [1:0]       D_fwd_rt,
  output logic [1:0]       E_fwd_rs,
  output logic [1:0]       E_fwd_rt,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int MD_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int MD_W   = $clog2(MD_MAX + 1);

  logic [MD_W-1:0] md_cnt;

  // Producer matches. Register 0 is hard-wired, so it never creates a
  // dependency and never forwards.
  logic d_rs_e, d_rs_m, d_rs_w;
  logic d_rt_e, d_rt_m, d_rt_w;
  logic e_rs_m, e_rs_w, e_rt_m, e_rt_w;

  assign d_rs_e = E_we && (E_a3 == D_a1) && (D_a1 != 5'd0);
  assign d_rs_m = M_we && (M_a3 == D_a1) && (D_a1 != 5'd0);
  assign d_rs_w = W_we && (W_a3 == D_a1) && (D_a1 != 5'd0);
  assign d_rt_e = E_we && (E_a3 == D_a2) && (D_a2 != 5'd0);
  assign d_rt_m = M_we && (M_a3 == D_a2) && (D_a2 != 5'd0);
  assign d_rt_w = W_we && (W_a3 == D_a2) && (D_a2 != 5'd0);
  assign e_rs_m = M_we && (M_a3 == E_a1) && (E_a1 != 5'd0);
  assign e_rs_w = W_we && (W_a3 == E_a1) && (E_a1 != 5'd0);
  assign e_rt_m = M_we && (M_a3 == E_a2) && (E_a2 != 5'd0);
  assign e_rt_w = W_we && (W_a3 == E_a2) && (E_a2 != 5'd0);

  // A stall is needed when the producer's result arrives later than the
  // consumer needs it. tuse=3 marks an unused operand.
  logic stall_rs, stall_rt, stall_md;

  assign stall_rs = (D_tuse_rs != 2'd3) &&
                    ((d_rs_e && (E_tnew > D_tuse_rs)) ||
                     (d_rs_m && (M_tnew > D_tuse_rs)));
  assign stall_rt = (D_tuse_rt != 2'd3) &&
                    ((d_rt_e && (E_tnew > D_tuse_rt)) ||
                     (d_rt_m && (M_tnew > D_tuse_rt)));
  // A start in E occupies the unit from the next edge on, so a HI/LO
  // consumer in D must already wait in that cycle.
  assign stall_md = D_md && (md_busy || E_start);
  assign stall    = stall_rs || stall_rt || stall_md;

  assign md_busy  = (md_cnt != '0);

  // Forward selects: the youngest ready producer wins.
  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    D_fwd_rs = 2'b00;
    D_fwd_rt = 2'b00;
    E_fwd_rs = 2'b00;
    E_fwd_rt = 2'b00;

    if (d_rs_e && (E_tnew == 2'd0))      D_fwd_rs = 2'b01;
    else if (d_rs_m && (M_tnew == 2'd0)) D_fwd_rs = 2'b10;
    else if (d_rs_w)                     D_fwd_rs = 2'b11;

    if (d_rt_e && (E_tnew == 2'd0))      D_fwd_rt = 2'b01;
    else if (d_rt_m && (M_tnew == 2'd0)) D_fwd_rt = 2'b10;
    else if (d_rt_w)                     D_fwd_rt = 2'b11;

    if (e_rs_m && (M_tnew == 2'd0))      E_fwd_rs = 2'b10;
    else if (e_rs_w)                     E_fwd_rs = 2'b01;

    if (e_rt_m && (M_tnew == 2'd0))      E_fwd_rt = 2'b10;
    else if (e_rt_w)                     E_fwd_rt = 2'b01;
  end

  // HI/LO busy counter. A start is accepted only when the unit is idle; a
  // start coinciding with the last busy cycle (md_cnt=1) is dropped.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      md_cnt <= '0;
    end else if (E_start && !md_busy) begin
      md_cnt <= E_div ? MD_W'(DIV_CYCLES) : MD_W'(MULT_CYCLES);
    end else if (md_busy) begin
      md_cnt <= md_cnt - MD_W'(1);
    end
  end

  // Stall cycle counter, saturating at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_unit
//
// Self-checking bench for hazard_unit. Two instances share all inputs: the
// default configuration and one with a 4-bit stall counter to exercise
// saturation. A behavioural model computes expected outputs from the
// dependency rules; the HI/LO unit is modelled as a "busy through cycle N"
// timestamp. Directed scenarios with literal expectations precede a
// randomized run.
// -----------------------------------------------------------------------------
module tb_hazard_unit;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  D_a1, D_a2, E_a1, E_a2, E_a3, M_a3, W_a3;
  logic [1:0]  D_tuse_rs, D_tuse_rt, E_tnew, M_tnew;
  logic        D_md, E_we, E_start, E_div, M_we, W_we;

  logic        stall, md_busy;
  logic [1:0]  D_fwd_rs, D_fwd_rt, E_fwd_rs, E_fwd_rt;
  logic [31:0] stall_cnt;

  logic        stall4, md_busy4;
  logic [1:0]  D_fwd_rs4, D_fwd_rt4, E_fwd_rs4, E_fwd_rt4;
  logic [3:0]  stall_cnt4;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: cycle index, last cycle the HI/LO unit is busy, stall count.
  int     cyc       = 1;
  int     busy_last = 0;
  longint m_cnt     = 0;

  always #5 clk = ~clk;

  hazard_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N), .CNT_W(32)) dut (
    .clk(clk), .reset(reset),
    .D_a1(D_a1), .D_a2(D_a2), .D_tuse_rs(D_tuse_rs), .D_tuse_rt(D_tuse_rt),
    .D_md(D_md),
    .E_a1(E_a1), .E_a2(E_a2), .E_a3(E_a3), .E_we(E_we), .E_tnew(E_tnew),
    .E_start(E_start), .E_div(E_div),
    .M_a3(M_a3), .M_we(M_we), .M_tnew(M_tnew),
    .W_a3(W_a3), .W_we(W_we),
    .stall(stall), .D_fwd_rs(D_fwd_rs), .D_fwd_rt(D_fwd_rt),
    .E_fwd_rs(E_fwd_rs), .E_fwd_rt(E_fwd_rt),
    .md_busy(md_busy), .stall_cnt(stall_cnt)
  );

  hazard_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset),
    .D_a1(D_a1), .D_a2(D_a2), .D_tuse_rs(D_tuse_rs), .D_tuse_rt(D_tuse_rt),
    .D_md(D_md),
    .E_a1(E_a1), .E_a2(E_a2), .E_a3(E_a3), .E_we(E_we), .E_tnew(E_tnew),
    .E_start(E_start), .E_div(E_div),
    .M_a3(M_a3), .M_we(M_we), .M_tnew(M_tnew),
    .W_a3(W_a3), .W_we(W_we),
    .stall(stall4), .D_fwd_rs(D_fwd_rs4), .D_fwd_rt(D_fwd_rt4),
    .E_fwd_rs(E_fwd_rs4), .E_fwd_rt(E_fwd_rt4),
    .md_busy(md_busy4), .stall_cnt(stall_cnt4)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic bit writes(input logic we, input logic [4:0] dst,
                                input logic [4:0] a);
    return we && dst == a && a != 5'd0;
  endfunction

  function automatic bit late(input logic [4:0] a, input logic [1:0] tuse);
    if (tuse == 2'd3) return 1'b0;
    return (writes(E_we, E_a3, a) && E_tnew > tuse) ||
           (writes(M_we, M_a3, a) && M_tnew > tuse);
  endfunction

  function automatic logic [1:0] d_src(input logic [4:0] a);
    if (writes(E_we, E_a3, a) && E_tnew == 0) return 2'd1;
    if (writes(M_we, M_a3, a) && M_tnew == 0) return 2'd2;
    if (writes(W_we, W_a3, a))                return 2'd3;
    return 2'd0;
  endfunction

  function automatic logic [1:0] e_src(input logic [4:0] a);
    if (writes(M_we, M_a3, a) && M_tnew == 0) return 2'b10;
    if (writes(W_we, W_a3, a))                return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit m_busy();
    return cyc <= busy_last;
  endfunction

  function automatic bit m_stall();
    return late(D_a1, D_tuse_rs) || late(D_a2, D_tuse_rt) ||
           (D_md && (m_busy() || E_start));
  endfunction

  function automatic longint sat(input longint v, input longint mx);
    return (v > mx) ? mx : v;
  endfunction

  // Compare every output of both instances against the model.
  task automatic compare();
    if (reset) begin
      busy_last = cyc - 1;
      m_cnt     = 0;
    end
    check("stall",     {31'd0, stall},     {31'd0, m_stall()});
    check("stall4",    {31'd0, stall4},    {31'd0, m_stall()});
    check("D_fwd_rs",  {30'd0, D_fwd_rs},  {30'd0, d_src(D_a1)});
    check("D_fwd_rt",  {30'd0, D_fwd_rt},  {30'd0, d_src(D_a2)});
    check("E_fwd_rs",  {30'd0, E_fwd_rs},  {30'd0, e_src(E_a1)});
    check("E_fwd_rt",  {30'd0, E_fwd_rt},  {30'd0, e_src(E_a2)});
    check("md_busy",   {31'd0, md_busy},   {31'd0, m_busy()});
    check("md_busy4",  {31'd0, md_busy4},  {31'd0, m_busy()});
    check("stall_cnt", stall_cnt,          32'(sat(m_cnt, 64'hFFFF_FFFF)));
    check("stall_cnt4", {28'd0, stall_cnt4}, 32'(sat(m_cnt, 15)));
  endtask

  // One clock: check settled outputs, advance model on the edge, return at
  // the following falling edge ready for new inputs.
  task automatic tick();
    bit s, go;
    #1;
    compare();
    s  = m_stall();
    go = E_start && !m_busy();
    @(posedge clk);
    cyc++;
    if (reset) begin
      busy_last = cyc - 1;
      m_cnt     = 0;
    end else begin
      if (go) busy_last = cyc + (E_div ? DIV_N : MULT_N) - 1;
      if (s)  m_cnt++;
    end
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    {D_a1, D_a2, E_a1, E_a2, E_a3, M_a3, W_a3} = '0;
    {D_tuse_rs, D_tuse_rt, E_tnew, M_tnew}     = '0;
    {D_md, E_we, E_start, E_div, M_we, W_we}   = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic load_use();
    E_we = 1'b1; E_a3 = 5'd8; E_tnew = 2'd2; D_a1 = 5'd8; D_tuse_rs = 2'd1;
  endtask

  int busy_seen;

  initial begin
    clear_inputs();
    reset = 1'b1;
    @(negedge clk);
    #1;
    // Reset state and all-zero inputs.
    check("rst_md_busy",   {31'd0, md_busy}, 32'd0);
    check("rst_stall_cnt", stall_cnt, 32'd0);
    check("zero_stall",    {31'd0, stall}, 32'd0);
    check("zero_fwd",      {24'd0, D_fwd_rs, D_fwd_rt, E_fwd_rs, E_fwd_rt}, 32'd0);
    tick();
    reset = 1'b0;
    tick();

    // Load-use: three stalled edges.
    load_use();
    #1;
    check("load_use_stall", {31'd0, stall}, 32'd1);
    for (int i = 0; i < 3; i++) tick();
    check("load_use_cnt", stall_cnt, 32'd3);

    // Branch operand forwarded from M.
    clear_inputs();
    M_we = 1'b1; M_a3 = 5'd9; M_tnew = 2'd0; D_a2 = 5'd9; D_tuse_rt = 2'd0;
    #1;
    check("branch_stall", {31'd0, stall}, 32'd0);
    check("branch_fwd_rt", {30'd0, D_fwd_rt}, 32'd2);
    tick();
    M_a3 = 5'd0; D_a2 = 5'd0;
    #1;
    check("r0_stall", {31'd0, stall}, 32'd0);
    check("r0_fwd_rt", {30'd0, D_fwd_rt}, 32'd0);
    tick();

    // Priority E > M > W.
    clear_inputs();
    E_we = 1'b1; E_a3 = 5'd4; M_we = 1'b1; M_a3 = 5'd4;
    W_we = 1'b1; W_a3 = 5'd4; D_a1 = 5'd4; D_tuse_rs = 2'd3; D_tuse_rt = 2'd3;
    #1;
    check("prio_e", {30'd0, D_fwd_rs}, 32'd1);
    tick();
    E_we = 1'b0;
    #1;
    check("prio_m", {30'd0, D_fwd_rs}, 32'd2);
    tick();

    // Divide: busy exactly DIV_N cycles with D_md stalling throughout; a
    // second start during busy is ignored.
    clear_inputs();
    E_start = 1'b1; E_div = 1'b1;
    tick();
    E_start = 1'b0; E_div = 1'b0; D_md = 1'b1;
    busy_seen = 0;
    for (int i = 0; i < 16; i++) begin
      E_start = (i == 3 || i == 9);
      #1;
      if (md_busy) begin
        busy_seen++;
        check("div_stall", {31'd0, stall}, 32'd1);
      end
      tick();
    end
    check("div_busy_cycles", busy_seen, 32'd10);

    // Reset mid-multiply aborts the operation immediately.
    clear_inputs();
    E_start = 1'b1;
    tick();
    E_start = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    #1;
    check("abort_md_busy",   {31'd0, md_busy}, 32'd0);
    check("abort_stall_cnt", stall_cnt, 32'd0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check("abort_after_busy", {31'd0, md_busy}, 32'd0);

    // Saturation of the 4-bit counter.
    do_reset();
    load_use();
    for (int i = 0; i < 20; i++) tick();
    check("sat_cnt4", {28'd0, stall_cnt4}, 32'd15);
    check("sat_cnt32", stall_cnt, 32'd20);

    // Randomized traffic: small address pool to force collisions.
    for (int i = 0; i < 3000; i++) begin
      D_a1 = 5'($urandom_range(0, 3));  D_a2 = 5'($urandom_range(0, 3));
      E_a1 = 5'($urandom_range(0, 3));  E_a2 = 5'($urandom_range(0, 3));
      E_a3 = 5'($urandom_range(0, 3));  M_a3 = 5'($urandom_range(0, 3));
      W_a3 = 5'($urandom_range(0, 3));
      D_tuse_rs = 2'($urandom_range(0, 3)); D_tuse_rt = 2'($urandom_range(0, 3));
      E_tnew = 2'($urandom_range(0, 3));    M_tnew = 2'($urandom_range(0, 3));
      E_we = 1'($urandom); M_we = 1'($urandom); W_we = 1'($urandom);
      D_md    = ($urandom_range(0, 2) == 0);
      E_start = ($urandom_range(0, 5) == 0);
      E_div   = 1'($urandom);
      reset   = ($urandom_range(0, 79) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
